// File: rtl/reg_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package reg_wb_arbiter_pkg;

    localparam int REG_LEN = 32;    // register width
    localparam int REG_NUM = 32;    // number of architectural registers (x0..x31)

    // Requester bit positions in the two-bit request/grant vectors
    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

    typedef enum logic {
        WB_ST_CLEAR = 1'b0,
        WB_ST_RUN   = 1'b1
    } wb_state_e;

    typedef enum logic {
        WB_PRIO_ALU = 1'b0,
        WB_PRIO_MEM = 1'b1
    } wb_prio_e;

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Writeback bus: ALU and load requesters, clear request, and the register-file write port.
interface reg_wb_arbiter_if #(
    parameter int ADDR_LEN = 5
) ();
    import reg_wb_arbiter_pkg::*;

    logic                clr_req;

    logic                alu_valid;
    logic [ADDR_LEN-1:0] alu_rd;
    logic [REG_LEN-1:0]  alu_data;
    logic                alu_ready;

    logic                mem_valid;
    logic [ADDR_LEN-1:0] mem_rd;
    logic [REG_LEN-1:0]  mem_data;
    logic                mem_ready;

    logic                reg_wr;
    logic [ADDR_LEN-1:0] rd;
    logic [REG_LEN-1:0]  rd_d;
    logic                busy;

    // Requester / register-file side
    modport master (
        output clr_req,
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        input  reg_wr, rd, rd_d, busy
    );

    // Arbiter side
    modport slave (
        input  clr_req,
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        output reg_wr, rd, rd_d, busy
    );

endinterface

// File: rtl/reg_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant, priority flop flips after each grant.
module rr_arb2
    import reg_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    wb_prio_e prio_q;
    wb_prio_e prio_d;

    // A lone requester wins outright; on a tie the side named by prio wins
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (prio_q == WB_PRIO_ALU) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    // After a grant the other side gets priority; with no grant priority holds
    always_comb begin
        prio_d = prio_q;
        if (gnt[REQ_ALU]) begin
            prio_d = WB_PRIO_MEM;
        end else if (gnt[REQ_MEM]) begin
            prio_d = WB_PRIO_ALU;
        end
    end

    // Priority register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= WB_PRIO_ALU;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Owns the register-file write port: clears x1..x31 after reset or on request,
// then shares the port round-robin between the ALU and load writeback paths.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int ADDR_LEN = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    reg_wb_arbiter_if.slave bus
);

    localparam logic [ADDR_LEN-1:0] CLR_FIRST = ADDR_LEN'(1);
    localparam logic [ADDR_LEN-1:0] CLR_LAST  = ADDR_LEN'(REG_NUM - 1);

    wb_state_e           state_q, state_d;
    logic [ADDR_LEN-1:0] clr_cnt_q, clr_cnt_d;

    // Output register feeding the register file write port
    logic                wr_en_q, wr_en_d;
    logic [ADDR_LEN-1:0] wr_addr_q, wr_addr_d;
    logic [REG_LEN-1:0]  wr_data_q, wr_data_d;

    logic                arb_en;
    logic [1:0]          gnt;

    // Arbitration only in RUN, and a clear request pre-empts any grant
    assign arb_en = (state_q == WB_ST_RUN) && !bus.clr_req;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   ({bus.mem_valid, bus.alu_valid}),
        .gnt   (gnt)
    );

    // State, clear counter and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WB_ST_CLEAR;
            clr_cnt_q <= CLR_FIRST;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Next state: CLEAR walks x1..x31 once, RUN returns to CLEAR on clr_req
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            WB_ST_CLEAR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    state_d   = WB_ST_RUN;
                    clr_cnt_d = CLR_FIRST;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_LEN'(1);
                end
            end
            WB_ST_RUN: begin
                if (bus.clr_req) begin
                    state_d   = WB_ST_CLEAR;
                    clr_cnt_d = CLR_FIRST;
                end
            end
            default: begin
                state_d = WB_ST_CLEAR;
            end
        endcase
    end

    // Output register load: clear write, granted request, or idle (address/data hold)
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (state_q == WB_ST_CLEAR) begin
            wr_en_d   = 1'b1;
            wr_addr_d = clr_cnt_q;
            wr_data_d = '0;
        end else if (gnt[REQ_ALU]) begin
            // x0 is hardwired: accept the request but suppress the write
            wr_en_d   = (bus.alu_rd != '0);
            wr_addr_d = bus.alu_rd;
            wr_data_d = bus.alu_data;
        end else if (gnt[REQ_MEM]) begin
            wr_en_d   = (bus.mem_rd != '0);
            wr_addr_d = bus.mem_rd;
            wr_data_d = bus.mem_data;
        end
    end

    assign bus.alu_ready = gnt[REQ_ALU];
    assign bus.mem_ready = gnt[REQ_MEM];
    assign bus.busy      = (state_q == WB_ST_CLEAR);
    assign bus.reg_wr    = wr_en_q;
    assign bus.rd        = wr_addr_q;
    assign bus.rd_d      = wr_data_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: clear sequence, directed vector table, clear/reset
// corner sequences, and a randomized phase against a behavioural model.
module tb_reg_wb_arbiter;
    import reg_wb_arbiter_pkg::*;

    localparam int AL = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    reg_wb_arbiter_if #(.ADDR_LEN(AL)) bus ();

    reg_wb_arbiter #(.ADDR_LEN(AL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Register file as seen from the write port (writes land on the edge after load)
    logic [REG_LEN-1:0] rf [REG_NUM] = '{default: 32'hBAD0_BAD0};
    int x0_writes = 0;
    always @(posedge clk) begin
        if (bus.reg_wr) begin
            rf[bus.rd] <= bus.rd_d;
            if (bus.rd == '0) x0_writes <= x0_writes + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [AL-1:0] ard, input logic [31:0] ad,
                         input logic mv, input logic [AL-1:0] mrd, input logic [31:0] md,
                         input logic clr);
        bus.alu_valid = av;  bus.alu_rd = ard;  bus.alu_data = ad;
        bus.mem_valid = mv;  bus.mem_rd = mrd;  bus.mem_data = md;
        bus.clr_req   = clr;
    endtask

    task automatic drive_idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    // Async reset pulse with requests pending; outputs must drop immediately
    task automatic assert_reset(input string tag);
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0);
        rst_n = 1'b0;
        #1;
        chk({tag, "_reg_wr"},    bus.reg_wr,    0);
        chk({tag, "_rd"},        bus.rd,        0);
        chk({tag, "_rd_d"},      bus.rd_d,      0);
        chk({tag, "_busy"},      bus.busy,      1);
        chk({tag, "_alu_ready"}, bus.alu_ready, 0);
        chk({tag, "_mem_ready"}, bus.mem_ready, 0);
        drive_idle();
        #12;
        rst_n = 1'b1;
    endtask

    // Full clear sequence with no traffic; starts before the first clear edge
    task automatic check_clear(input string tag);
        for (int i = 1; i <= REG_NUM - 1; i++) begin
            @(posedge clk); #1;
            chk({tag, "_wr"},   bus.reg_wr, 1);
            chk({tag, "_rd"},   bus.rd,     i);
            chk({tag, "_data"}, bus.rd_d,   0);
            chk({tag, "_busy"}, bus.busy,   (i < REG_NUM - 1));
        end
        @(posedge clk); #1;
        chk({tag, "_idle_wr"}, bus.reg_wr, 0);
        chk({tag, "_busy_end"}, bus.busy, 0);
        for (int r = 1; r < REG_NUM; r++) begin
            chk($sformatf("%s_rf_x%0d", tag, r), rf[r], 0);
        end
    endtask

    typedef struct {
        logic           av;
        logic [AL-1:0]  ard;
        logic [31:0]    ad;
        logic           mv;
        logic [AL-1:0]  mrd;
        logic [31:0]    md;
        logic           clr;
        logic           e_ar;
        logic           e_mr;
        logic           e_wr;
        logic [AL-1:0]  e_rd;
        logic [31:0]    e_d;
        logic           chk_addr;
    } vec_t;

    function automatic vec_t mk(logic av, logic [AL-1:0] ard, logic [31:0] ad,
                                logic mv, logic [AL-1:0] mrd, logic [31:0] md, logic clr,
                                logic ear, logic emr, logic ewr, logic [AL-1:0] erd,
                                logic [31:0] ed, logic ck);
        vec_t v;
        v.av = av;  v.ard = ard;  v.ad = ad;
        v.mv = mv;  v.mrd = mrd;  v.md = md;  v.clr = clr;
        v.e_ar = ear;  v.e_mr = emr;  v.e_wr = ewr;  v.e_rd = erd;  v.e_d = ed;
        v.chk_addr = ck;
        return v;
    endfunction

    localparam int NV = 12;
    vec_t vec [NV];

    function automatic logic [AL-1:0] rnd_rd();
        if ($urandom_range(0, 7) == 0) return '0;
        return AL'($urandom_range(1, REG_NUM - 1));
    endfunction

    // Behavioural model state for the random phase
    int            m_left;
    int            m_idx;
    bit            m_tie_mem;
    bit            m_wr;
    bit            m_dc;
    logic [AL-1:0] m_rd;
    logic [31:0]   m_data;
    logic [31:0]   exp_rf [REG_NUM];

    initial begin
        // Tie-break after reset goes to ALU, then alternates after every grant
        vec[0]  = mk(1, 1,  32'h1,        1, 9,  32'h99,   0, 1, 0, 1, 1,  32'h1,        1);
        vec[1]  = mk(1, 2,  32'h2,        1, 9,  32'h99,   0, 0, 1, 1, 9,  32'h99,       1);
        vec[2]  = mk(1, 2,  32'h2,        1, 9,  32'h99,   0, 1, 0, 1, 2,  32'h2,        1);
        vec[3]  = mk(1, 3,  32'h3,        1, 9,  32'h99,   0, 0, 1, 1, 9,  32'h99,       1);
        vec[4]  = mk(1, 3,  32'h3,        0, 0,  32'h0,    0, 1, 0, 1, 3,  32'h3,        1);
        vec[5]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  32'h0,    0, 1, 0, 1, 5,  32'hDEADBEEF, 1);
        vec[6]  = mk(1, 7,  32'h77,       1, 0,  32'h1234, 0, 0, 1, 0, 0,  32'h0,        0);
        vec[7]  = mk(1, 7,  32'h77,       0, 0,  32'h0,    0, 1, 0, 1, 7,  32'h77,       1);
        vec[8]  = mk(0, 0,  32'h0,        0, 0,  32'h0,    0, 0, 0, 0, 7,  32'h77,       1);
        vec[9]  = mk(1, 12, 32'hAAAA,     1, 12, 32'hBBBB, 0, 0, 1, 1, 12, 32'hBBBB,     1);
        vec[10] = mk(1, 12, 32'hAAAA,     0, 0,  32'h0,    0, 1, 0, 1, 12, 32'hAAAA,     1);
        vec[11] = mk(1, 6,  32'h66,       0, 0,  32'h0,    1, 0, 0, 0, 12, 32'hAAAA,     1);

        drive_idle();
        #1;
        assert_reset("rst0");
        check_clear("clr0");

        // Directed vectors in RUN
        for (int i = 0; i < NV; i++) begin
            drive(vec[i].av, vec[i].ard, vec[i].ad, vec[i].mv, vec[i].mrd, vec[i].md, vec[i].clr);
            @(negedge clk);
            chk($sformatf("v%0d_alu_ready", i), bus.alu_ready, vec[i].e_ar);
            chk($sformatf("v%0d_mem_ready", i), bus.mem_ready, vec[i].e_mr);
            chk($sformatf("v%0d_busy", i),      bus.busy,      0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_reg_wr", i), bus.reg_wr, vec[i].e_wr);
            if (vec[i].chk_addr) begin
                chk($sformatf("v%0d_rd", i),   bus.rd,   vec[i].e_rd);
                chk($sformatf("v%0d_rd_d", i), bus.rd_d, vec[i].e_d);
            end
        end
        chk("rf_x5",  rf[5],  32'hDEADBEEF);
        chk("rf_x12", rf[12], 32'hAAAA);
        chk("rf_x9",  rf[9],  32'h99);
        chk("rf_x7",  rf[7],  32'h77);
        chk("x0_writes", x0_writes, 0);

        // Clear requested alongside an ALU request: the request waits out the clear
        drive(1, 6, 32'h66, 0, 0, 0, 0);
        for (int i = 1; i <= REG_NUM - 1; i++) begin
            @(negedge clk);
            chk("clr1_alu_ready", bus.alu_ready, 0);
            chk("clr1_busy",      bus.busy,      1);
            @(posedge clk); #1;
            chk("clr1_wr", bus.reg_wr, 1);
            chk("clr1_rd", bus.rd,     i);
            chk("clr1_d",  bus.rd_d,   0);
        end
        @(negedge clk);
        chk("clr1_first_run_alu_ready", bus.alu_ready, 1);
        chk("clr1_first_run_busy",      bus.busy,      0);
        @(posedge clk); #1;
        drive_idle();
        chk("clr1_held_wr",   bus.reg_wr, 1);
        chk("clr1_held_rd",   bus.rd,     6);
        chk("clr1_held_d",    bus.rd_d,   32'h66);
        chk("clr1_rf_x12",    rf[12],     0);

        // Reset pulsed during clear cycle 10
        drive(0, 0, 0, 0, 0, 0, 1);
        @(posedge clk); #1;
        drive_idle();
        chk("clr2_start_wr", bus.reg_wr, 0);
        chk("clr2_start_busy", bus.busy, 1);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            chk("clr2_pre_rd", bus.rd, i);
        end
        assert_reset("rst_mid");
        check_clear("clr3");

        // Randomized traffic against the behavioural model, starting from reset
        assert_reset("rst_rnd");
        m_left = REG_NUM - 1;  m_idx = 1;  m_tie_mem = 0;
        m_wr = 0;  m_dc = 0;  m_rd = '0;  m_data = '0;
        for (int r = 0; r < REG_NUM; r++) exp_rf[r] = '0;
        begin
            bit            a_pend, p_pend, clr, busy_e, wa, wm;
            logic [AL-1:0] a_rd, p_rd;
            logic [31:0]   a_d, p_d;
            a_pend = 0;  p_pend = 0;
            a_rd = '0;  p_rd = '0;  a_d = '0;  p_d = '0;
            for (int c = 0; c < 700; c++) begin
                if (!a_pend && $urandom_range(0, 9) < 7) begin
                    a_pend = 1;  a_rd = rnd_rd();  a_d = $urandom;
                end
                if (!p_pend && $urandom_range(0, 9) < 7) begin
                    p_pend = 1;  p_rd = rnd_rd();  p_d = $urandom;
                end
                clr = ($urandom_range(0, 99) < 3);
                drive(a_pend, a_rd, a_d, p_pend, p_rd, p_d, clr);
                @(negedge clk);
                busy_e = (m_left > 0);
                wa = 0;  wm = 0;
                if (!busy_e && !clr) begin
                    if (a_pend && p_pend) begin
                        wa = !m_tie_mem;  wm = m_tie_mem;
                    end else begin
                        wa = a_pend;  wm = p_pend;
                    end
                end
                chk("rnd_busy",      bus.busy,      busy_e);
                chk("rnd_alu_ready", bus.alu_ready, wa);
                chk("rnd_mem_ready", bus.mem_ready, wm);
                if (m_wr) exp_rf[m_rd] = m_data;
                if (busy_e) begin
                    m_wr = 1;  m_dc = 0;  m_rd = AL'(m_idx);  m_data = '0;
                    m_idx++;  m_left--;
                end else if (clr) begin
                    m_wr = 0;  m_left = REG_NUM - 1;  m_idx = 1;
                end else if (wa || wm) begin
                    m_tie_mem = wa;
                    m_rd   = wa ? a_rd : p_rd;
                    m_data = wa ? a_d  : p_d;
                    m_wr   = (m_rd != '0);
                    m_dc   = (m_rd == '0);
                end else begin
                    m_wr = 0;
                end
                @(posedge clk); #1;
                chk("rnd_reg_wr", bus.reg_wr, m_wr);
                if (!m_dc) begin
                    chk("rnd_rd",   bus.rd,   m_rd);
                    chk("rnd_rd_d", bus.rd_d, m_data);
                end
                if (wa) a_pend = 0;
                if (wm) p_pend = 0;
            end
        end
        drive_idle();
        if (m_wr) exp_rf[m_rd] = m_data;
        @(posedge clk); #1;
        for (int r = 1; r < REG_NUM; r++) begin
            chk($sformatf("rnd_rf_x%0d", r), rf[r], exp_rf[r]);
        end
        chk("rnd_x0_writes", x0_writes, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
